// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader.
// Writes each accepted byte to IMEM and assembles big-endian words.
module imem_loader (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [9:0]  BASE_ADDR,
  input  logic [8:0]  WORD_COUNT,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic        MEM_WE,
  output logic [9:0]  MEM_ADDR,
  output logic [7:0]  MEM_WDATA,
  output logic [31:0] WORD_OUT,
  output logic        WORD_STROBE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FIN
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [9:0]  cur_addr;
  logic [10:0] idx;
  logic [10:0] total;
  logic [1:0]  lane;
  logic [23:0] part;
  logic        start_ok;
  logic        accept;
  logic        last;
  logic        misalign;

  assign start_ok = (state == S_IDLE) && START;
  assign accept   = (state == S_LOAD) && BYTE_VALID;
  assign last     = (idx == total - 11'd1);
  assign misalign = |BASE_ADDR[1:0];

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (START) begin
          if (misalign || WORD_COUNT == 9'd0)
            state_n = S_FIN;
          else
            state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept && last) state_n = S_FIN;
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    BYTE_READY = (state == S_LOAD);
    BUSY       = (state == S_LOAD);
    DONE       = (state == S_FIN);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cur_addr    <= '0;
      idx         <= '0;
      total       <= '0;
      lane        <= '0;
      part        <= '0;
      MEM_WE      <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_WDATA   <= '0;
      WORD_OUT    <= '0;
      WORD_STROBE <= 1'b0;
      ERROR       <= 1'b0;
    end else begin
      MEM_WE      <= 1'b0;
      WORD_STROBE <= 1'b0;
      if (start_ok) begin
        cur_addr <= BASE_ADDR;
        total    <= {WORD_COUNT, 2'b00};
        idx      <= '0;
        lane     <= '0;
        part     <= '0;
        ERROR    <= misalign;
      end
      if (accept) begin
        MEM_WE    <= 1'b1;
        MEM_ADDR  <= cur_addr;
        MEM_WDATA <= BYTE_IN;
        cur_addr  <= cur_addr + 10'd1;
        idx       <= idx + 11'd1;
        lane      <= lane + 2'd1;
        part      <= {part[15:0], BYTE_IN};
        if (lane == 2'd3) begin
          WORD_OUT    <= {part, BYTE_IN};
          WORD_STROBE <= 1'b1;
        end
        // address counter wrapped past 1023 within this session
        if (cur_addr == 10'd0 && idx != 11'd0)
          ERROR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed table, reset abort,
// and randomized sessions against a queue-based reference model.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [9:0]  BASE_ADDR;
  logic [8:0]  WORD_COUNT;
  logic [7:0]  BYTE_IN;
  logic        BYTE_VALID;
  logic        BYTE_READY;
  logic        MEM_WE;
  logic [9:0]  MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic [31:0] WORD_OUT;
  logic        WORD_STROBE;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;

  imem_loader dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .BASE_ADDR(BASE_ADDR), .WORD_COUNT(WORD_COUNT),
    .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .WORD_OUT(WORD_OUT), .WORD_STROBE(WORD_STROBE),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [9:0]  base;
    int          cnt;
    int          gap;
    bit          err;
    bit          busy;
    logic [7:0]  b[8];
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  wr_t         exp_wr[$];
  logic [31:0] exp_word[$];
  int          done_cnt = 0;
  bit          busy_seen = 0;
  bit          acc_prev = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    wr_t w;
    if (MEM_WE === 1'b1 || acc_prev)
      chk("we_timing", {31'd0, MEM_WE}, {31'd0, acc_prev});
    if (MEM_WE === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_write actual=%0h required=none", MEM_ADDR);
      end else begin
        w = exp_wr.pop_front();
        chk("mem_addr", {22'd0, MEM_ADDR}, {22'd0, w.addr});
        chk("mem_wdata", {24'd0, MEM_WDATA}, {24'd0, w.data});
      end
    end
    if (WORD_STROBE === 1'b1) begin
      chk("strobe_with_we", {31'd0, MEM_WE}, 32'd1);
      if (exp_word.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_strobe actual=%0h required=none", WORD_OUT);
      end else begin
        chk("word_out", WORD_OUT, exp_word.pop_front());
      end
    end
    if (DONE === 1'b1) begin
      done_cnt++;
      chk("fin_flags", {30'd0, BUSY, BYTE_READY}, 32'd0);
    end
    if (BUSY === 1'b1) busy_seen = 1;
    acc_prev = (BYTE_VALID && BYTE_READY === 1'b1 && !RESET);
  end

  task automatic feed(input logic [7:0] b[$], input int n,
                      input int gap, input bit noisy);
    int  idx;
    int  cyc;
    bit  phase;
    bit  v;
    idx = 0;
    cyc = 0;
    phase = 0;
    while (idx < n && cyc < 5000) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? phase : ($urandom % 3 != 0);
      phase = ~phase;
      BYTE_VALID = v;
      BYTE_IN = v ? b[idx] : 8'($urandom);
      START = noisy && ($urandom % 4 == 0);
      BASE_ADDR = 10'($urandom);
      WORD_COUNT = 9'($urandom);
      if (v && BYTE_READY) idx++;
      tick();
      cyc++;
    end
    if (idx < n) begin
      checks++;
      failures++;
      $display("FAIL feed_timeout actual=%0d required=%0d", idx, n);
    end
    BYTE_VALID = 0;
    START = 0;
  endtask

  task automatic session(input logic [9:0] base, input int cnt,
                         input logic [7:0] b[$], input logic [31:0] w[$],
                         input int gap, input bit noisy,
                         input bit exp_err, input bit exp_busy);
    int  n;
    wr_t e;
    n = exp_busy ? 4 * cnt : 0;
    for (int k = 0; k < n; k++) begin
      e.addr = 10'((int'(base) + k) % 1024);
      e.data = b[k];
      exp_wr.push_back(e);
    end
    if (exp_busy)
      foreach (w[i]) exp_word.push_back(w[i]);
    done_cnt = 0;
    busy_seen = 0;
    START = 1;
    BASE_ADDR = base;
    WORD_COUNT = 9'(cnt);
    BYTE_VALID = 0;
    tick();
    START = 0;
    if (!exp_busy) chk("done_next", {31'd0, DONE}, 32'd1);
    feed(b, n, gap, noisy);
    BYTE_VALID = 1;
    BYTE_IN = 8'hee;
    repeat (3) tick();
    BYTE_VALID = 0;
    chk("done_count", done_cnt, 1);
    chk("writes_left", exp_wr.size(), 0);
    chk("words_left", exp_word.size(), 0);
    chk("error", {31'd0, ERROR}, {31'd0, exp_err});
    chk("busy_seen", {31'd0, busy_seen}, {31'd0, exp_busy});
    exp_wr.delete();
    exp_word.delete();
  endtask

  task automatic chk_zero(input string name);
    chk(name, {26'd0, BYTE_READY, MEM_WE, WORD_STROBE, BUSY, DONE, ERROR}, 32'd0);
    chk({name, "_addr"}, {22'd0, MEM_ADDR}, 32'd0);
    chk({name, "_wdata"}, {24'd0, MEM_WDATA}, 32'd0);
    chk({name, "_word"}, WORD_OUT, 32'd0);
  endtask

  function automatic bit model_err(int base, int cnt);
    return (base % 4 != 0) || (cnt != 0 && base + 4 * cnt > 1024);
  endfunction

  vec_t        tbl[5];
  logic [7:0]  bq[$];
  logic [31:0] wq[$];
  logic [9:0]  rb;
  int          rc;
  int          rg;

  initial begin
    tbl[0] = '{10'd0, 1, 0, 1'b0, 1'b1,
               '{8'h00, 8'h01, 8'h10, 8'h20, 8'h0, 8'h0, 8'h0, 8'h0},
               32'h00011020, 32'h0};
    tbl[1] = '{10'd4, 2, 1, 1'b0, 1'b1,
               '{8'h00, 8'h64, 8'h28, 8'h24, 8'h01, 8'h27, 8'h40, 8'h25},
               32'h00642824, 32'h01274025};
    tbl[2] = '{10'd8, 0, 0, 1'b0, 1'b0,
               '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
               32'h0, 32'h0};
    tbl[3] = '{10'd2, 1, 0, 1'b1, 1'b0,
               '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
               32'h0, 32'h0};
    tbl[4] = '{10'd1020, 2, 2, 1'b1, 1'b1,
               '{8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7, 8'ha8},
               32'ha1a2a3a4, 32'ha5a6a7a8};

    RESET = 1;
    START = 0;
    BASE_ADDR = 0;
    WORD_COUNT = 0;
    BYTE_IN = 0;
    BYTE_VALID = 0;
    repeat (2) tick();
    chk_zero("reset_state");
    RESET = 0;
    tick();

    for (int i = 0; i < 5; i++) begin
      bq.delete();
      wq.delete();
      for (int k = 0; k < 8; k++) bq.push_back(tbl[i].b[k]);
      if (tbl[i].cnt > 0) wq.push_back(tbl[i].w0);
      if (tbl[i].cnt > 1) wq.push_back(tbl[i].w1);
      session(tbl[i].base, tbl[i].cnt, bq, wq, tbl[i].gap, 1'b0,
              tbl[i].err, tbl[i].busy);
    end

    // reset in the middle of a two-word load
    bq.delete();
    bq.push_back(8'h11);
    bq.push_back(8'h22);
    bq.push_back(8'h33);
    for (int k = 0; k < 3; k++) exp_wr.push_back('{10'(k), bq[k]});
    done_cnt = 0;
    START = 1;
    BASE_ADDR = 10'd0;
    WORD_COUNT = 9'd2;
    tick();
    START = 0;
    feed(bq, 3, 0, 1'b0);
    RESET = 1;
    START = 1;
    BYTE_VALID = 1;
    BYTE_IN = 8'h44;
    tick();
    RESET = 0;
    START = 0;
    BYTE_VALID = 0;
    chk_zero("abort_state");
    repeat (3) tick();
    chk("abort_done", done_cnt, 0);
    chk("abort_writes", exp_wr.size(), 0);
    exp_wr.delete();
    bq.delete();
    wq.delete();
    for (int k = 0; k < 8; k++) bq.push_back(tbl[0].b[k]);
    wq.push_back(tbl[0].w0);
    session(10'd0, 1, bq, wq, 0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      if (i == 0)                rb = 10'd0;
      else if (i == 1)           rb = 10'd4;
      else if ($urandom % 8 == 0) rb = 10'($urandom);
      else if ($urandom % 4 == 0) rb = 10'(1024 - 4 * ($urandom_range(1, 4)));
      else                        rb = {8'($urandom), 2'b00};
      rc = (i < 2) ? 256 : int'($urandom % 7);
      rg = int'($urandom % 3);
      bq.delete();
      wq.delete();
      for (int k = 0; k < 4 * rc; k++) bq.push_back(8'($urandom));
      for (int k = 0; k < rc; k++)
        wq.push_back({bq[4*k], bq[4*k+1], bq[4*k+2], bq[4*k+3]});
      session(rb, rc, bq, wq, rg, 1'b1, model_err(int'(rb), rc),
              (rb[1:0] == 2'b00) && (rc != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have port CLK  in  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET  in  1  synchronous reset, active-high.
REQ-003 SHALL have port START  in  1  begin a load session; sampled only in IDLE.
REQ-004 SHALL have port BASE_ADDR  in  10  byte address of the first byte; sampled with START.
REQ-005 SHALL have port WORD_COUNT  in  9  number of 32-bit words to load (0..256); sampled with START.
REQ-006 SHALL have port BYTE_IN  in  8  incoming instruction byte.
REQ-007 SHALL have port BYTE_VALID  in  1  BYTE_IN is valid.
REQ-008 SHALL have port BYTE_READY  out  1  loader accepts a byte this cycle.
REQ-009 SHALL have port MEM_WE  out  1  byte write strobe to instruction memory.
REQ-010 SHALL have port MEM_ADDR  out  10  byte write address.
REQ-011 SHALL have port MEM_WDATA  out  8  byte write data.
REQ-012 SHALL have port WORD_OUT  out  32  last fully assembled word.
REQ-013 SHALL have port WORD_STROBE  out  1  one-cycle pulse, WORD_OUT just updated.
REQ-014 SHALL have port BUSY  out  1  high in LOAD.
REQ-015 SHALL have port DONE  out  1  one-cycle pulse at session end.
REQ-016 SHALL have port ERROR  out  1  sticky session error flag.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD -> FIN -> IDLE; FIN lasts exactly one cycle.
REQ-018 IDLE & START: latch BASE_ADDR, WORD_COUNT; clear ERROR, byte index, lane counter.
REQ-019 IDLE & START & BASE_ADDR[1:0]!=0: ERROR=1, go to FIN, no memory writes.
REQ-020 IDLE & START & WORD_COUNT==0: go to FIN, ERROR=0, no memory writes.
REQ-021 START outside IDLE SHALL be ignored.
REQ-022 BYTE_READY SHALL be 1 only in LOAD; a byte is accepted on an edge where BYTE_VALID & BYTE_READY.
REQ-023 Accepted byte k (k=0..4*WORD_COUNT-1) SHALL produce MEM_WE=1 in the following cycle with MEM_ADDR=(base+k) mod 1024 and MEM_WDATA=byte; MEM_WE=0 otherwise.
REQ-024 Big-endian assembly: lane 0 -> WORD_OUT[31:24], lane 1 -> [23:16], lane 2 -> [15:8], lane 3 -> [7:0]; lane counter wraps 3->0.
REQ-025 Lane-3 acceptance SHALL update WORD_OUT and pulse WORD_STROBE in the next cycle (same cycle as that byte's MEM_WE).
REQ-026 Acceptance of the final byte SHALL move LOAD->FIN; BYTE_READY=0 from the next cycle.
REQ-027 DONE SHALL be 1 exactly during the FIN cycle; BUSY=0 in FIN.
REQ-028 Address crossing 1023->0 SHALL wrap to 0 and set ERROR=1, held until next accepted START or RESET.
REQ-029 Gaps in BYTE_VALID SHALL stall with no writes and no state loss; no timeout.
REQ-030 BYTE_VALID in IDLE/FIN SHALL be ignored (no write, no state change).

Reset
REQ-031 RESET SHALL force IDLE; BYTE_READY, MEM_WE, WORD_STROBE, BUSY, DONE, ERROR = 0; MEM_ADDR, MEM_WDATA = 0; WORD_OUT = 32'h0.
REQ-032 RESET mid-LOAD SHALL abort: no MEM_WE in the cycle after reset, no DONE, partial word discarded.
REQ-033 RESET SHALL take priority over START and BYTE_VALID in the same cycle.

Verification
REQ-034 START, BASE=0, COUNT=1, bytes 00,01,10,20 back-to-back -> writes addr 0..3 with 00,01,10,20; WORD_STROBE with WORD_OUT=32'h00011020; DONE one cycle later; ERROR=0.
REQ-035 START, BASE=4, COUNT=2, bytes 00,64,28,24,01,27,40,25 with BYTE_VALID low every other cycle -> writes addr 4..11 in order; WORD_OUT 32'h00642824 then 32'h01274025; no writes in gap cycles.
REQ-036 START, COUNT=0 -> DONE next cycle, BUSY never 1, no MEM_WE, ERROR=0.
REQ-037 START, BASE=2, COUNT=1 -> ERROR=1, DONE pulse, no MEM_WE.
REQ-038 START, BASE=1020, COUNT=2, 8 bytes -> addr 1020..1023 then 0..3; ERROR=1 after crossing; DONE pulse; ERROR stays 1 until next START.
REQ-039 START, BASE=0, COUNT=2, RESET after 3 bytes -> all outputs 0 next cycle, no further MEM_WE, no DONE; subsequent START then COUNT=1 load behaves as REQ-034.
